// File: rtl/piso_register.sv
// ---------------------------------------------------------------------------
// piso_register
//
// Parallel-in, serial-out transmit register. A WIDTH-bit word is captured
// from the parallel data bus when the block is idle and load is high. It is
// then shifted out one bit per clock on sout, qualified by sout_valid. A
// one-cycle done pulse follows the last bit of the frame.
//
// Handshake: a word transfers on a rising edge where load=1 and ready=1.
// load has no effect while ready=0, and requests are not queued. Once
// accepted, the frame runs to completion. hold=1 can stretch the frame;
// only an active-low rst_ can abort it.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports:
//   clk         system clock, rising edge
//   rst_        asynchronous active-low reset
//   data        parallel word, sampled on the load acceptance edge
//   load        load request, accepted only when ready=1
//   hold        pause request, freezes shifting while in SHIFT
//   ready       idle and able to accept load
//   sout        serial data bit
//   sout_valid  sout carries a frame bit this cycle
//   done        one-cycle pulse after the last bit of a frame
//   state_dbg   current FSM state (IDLE=0, SHIFT=1, DONE=2) for observation
// ---------------------------------------------------------------------------
module piso_register #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             hold,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic             head;
  logic [WIDTH-1:0] shreg_next;

  // The head is the bit currently presented on sout. Shifting moves the
  // next bit into the head position and zero-fills the far end.
  always_comb begin
    head       = 1'b0;
    shreg_next = '0;
    if (MSB_FIRST) begin
      head       = shreg[WIDTH-1];
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      head       = shreg[0];
      shreg_next = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= data;
            cnt   <= CNT_LAST;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // hold freezes everything, so the bit on sout is neither lost
          // nor repeated once shifting resumes.
          if (!hold) begin
            if (cnt == '0) begin
              state <= DONE;
            end else begin
              shreg <= shreg_next;
              cnt   <= cnt - 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode from registered state. sout_valid additionally
  // follows hold so a paused bit is not counted twice by the receiver.
  always_comb begin
    ready      = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      SHIFT: begin
        sout       = head;
        sout_valid = ~hold;
      end
      DONE:    done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_piso_register.sv
module tb_piso_register;

  logic       clk;
  logic       rst_;
  logic [7:0] data;
  logic       load;
  logic       hold;

  logic       ready_m, sout_m, sout_valid_m, done_m;
  logic [1:0] state_m;
  logic       ready_l, sout_l, sout_valid_l, done_l;
  logic [1:0] state_l;

  int total = 0;
  int bad   = 0;

  piso_register #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst_       (rst_),
    .data       (data),
    .load       (load),
    .hold       (hold),
    .ready      (ready_m),
    .sout       (sout_m),
    .sout_valid (sout_valid_m),
    .done       (done_m),
    .state_dbg  (state_m)
  );

  piso_register #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst_       (rst_),
    .data       (data),
    .load       (load),
    .hold       (hold),
    .ready      (ready_l),
    .sout       (sout_l),
    .sout_valid (sout_valid_l),
    .done       (done_l),
    .state_dbg  (state_l)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst_ = 1'b0;
    data = 'x;
    load = 1'b1;
    hold = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++; if (ready_m !== 1'b1) begin bad++; $display("FAIL reset_ready c=%0d got=%b want=1", c, ready_m); end
      total++; if (sout_m !== 1'b0) begin bad++; $display("FAIL reset_sout c=%0d got=%b want=0", c, sout_m); end
      total++; if (sout_valid_m !== 1'b0) begin bad++; $display("FAIL reset_valid c=%0d got=%b want=0", c, sout_valid_m); end
      total++; if (done_m !== 1'b0) begin bad++; $display("FAIL reset_done c=%0d got=%b want=0", c, done_m); end
      total++; if (state_m !== 2'd0) begin bad++; $display("FAIL reset_state c=%0d got=%0d want=0", c, state_m); end
    end
    rst_ = 1'b1;
    load = 1'b0;
    data = 8'h00;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++; if (ready_m !== 1'b1) begin bad++; $display("FAIL post_reset_ready c=%0d got=%b want=1", c, ready_m); end
      total++; if (sout_valid_m !== 1'b0) begin bad++; $display("FAIL post_reset_valid c=%0d got=%b want=0", c, sout_valid_m); end
    end
  endtask

  task automatic test_basic_frame;
    logic [7:0] exp_s;
    exp_s = 8'b1010_0101;   // stream order, first bit leftmost
    @(negedge clk);
    data = 8'hA5;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (sout_m !== exp_s[7-k]) begin bad++; $display("FAIL basic_sout k=%0d got=%b want=%b", k, sout_m, exp_s[7-k]); end
      total++; if (sout_valid_m !== 1'b1) begin bad++; $display("FAIL basic_valid k=%0d got=%b want=1", k, sout_valid_m); end
      total++; if (ready_m !== 1'b0) begin bad++; $display("FAIL basic_ready k=%0d got=%b want=0", k, ready_m); end
      @(negedge clk);
    end
    #1;
    total++; if (done_m !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done_m); end
    total++; if (sout_valid_m !== 1'b0) begin bad++; $display("FAIL basic_done_valid got=%b want=0", sout_valid_m); end
    total++; if (ready_m !== 1'b0) begin bad++; $display("FAIL basic_done_ready got=%b want=0", ready_m); end
    @(negedge clk); #1;
    total++; if (ready_m !== 1'b1) begin bad++; $display("FAIL basic_end_ready got=%b want=1", ready_m); end
    total++; if (done_m !== 1'b0) begin bad++; $display("FAIL basic_end_done got=%b want=0", done_m); end
  endtask

  task automatic test_load_while_busy;
    logic [7:0] exp_s;
    exp_s = 8'b0011_1100;
    @(negedge clk);
    data = 8'h3C;
    load = 1'b1;
    @(negedge clk);
    data = 8'hFF;   // load stays high for the whole frame
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (sout_m !== exp_s[7-k]) begin bad++; $display("FAIL busy_sout k=%0d got=%b want=%b", k, sout_m, exp_s[7-k]); end
      total++; if (sout_valid_m !== 1'b1) begin bad++; $display("FAIL busy_valid k=%0d got=%b want=1", k, sout_valid_m); end
      total++; if (ready_m !== 1'b0) begin bad++; $display("FAIL busy_ready k=%0d got=%b want=0", k, ready_m); end
      @(negedge clk);
    end
    #1;
    total++; if (done_m !== 1'b1) begin bad++; $display("FAIL busy_done got=%b want=1", done_m); end
    total++; if (ready_m !== 1'b0) begin bad++; $display("FAIL busy_done_ready got=%b want=0", ready_m); end
    @(negedge clk); #1;
    total++; if (ready_m !== 1'b1) begin bad++; $display("FAIL busy_idle_ready got=%b want=1", ready_m); end
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (sout_m !== 1'b1) begin bad++; $display("FAIL busy_ff_sout k=%0d got=%b want=1", k, sout_m); end
      total++; if (sout_valid_m !== 1'b1) begin bad++; $display("FAIL busy_ff_valid k=%0d got=%b want=1", k, sout_valid_m); end
      @(negedge clk);
    end
    #1;
    total++; if (done_m !== 1'b1) begin bad++; $display("FAIL busy_ff_done got=%b want=1", done_m); end
    @(negedge clk); #1;
    total++; if (ready_m !== 1'b1) begin bad++; $display("FAIL busy_ff_ready got=%b want=1", ready_m); end
  endtask

  task automatic test_hold;
    logic [7:0] exp_s;
    int idx;
    exp_s = 8'b1100_0011;
    idx = 0;
    @(negedge clk);
    data = 8'hC3;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    // cycles 3 and 4 are held while bit index 3 is on sout
    for (int c = 0; c < 10; c++) begin
      hold = (c == 3 || c == 4);
      #1;
      total++; if (done_m !== 1'b0) begin bad++; $display("FAIL hold_early_done c=%0d got=%b want=0", c, done_m); end
      total++; if (sout_m !== exp_s[7-idx]) begin bad++; $display("FAIL hold_sout c=%0d got=%b want=%b", c, sout_m, exp_s[7-idx]); end
      if (hold) begin
        total++; if (sout_valid_m !== 1'b0) begin bad++; $display("FAIL hold_valid c=%0d got=%b want=0", c, sout_valid_m); end
      end else begin
        total++; if (sout_valid_m !== 1'b1) begin bad++; $display("FAIL hold_run_valid c=%0d got=%b want=1", c, sout_valid_m); end
        idx++;
      end
      @(negedge clk);
    end
    hold = 1'b0;
    #1;
    total++; if (done_m !== 1'b1) begin bad++; $display("FAIL hold_done got=%b want=1", done_m); end
    @(negedge clk); #1;
    total++; if (ready_m !== 1'b1) begin bad++; $display("FAIL hold_ready got=%b want=1", ready_m); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] exp_s;
    exp_s = 8'b0101_1010;
    @(negedge clk);
    data = 8'h5A;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++; if (sout_m !== exp_s[7-k]) begin bad++; $display("FAIL mid_sout k=%0d got=%b want=%b", k, sout_m, exp_s[7-k]); end
    end
    @(negedge clk);
    #2;
    rst_ = 1'b0;
    #1;   // still before the next rising edge
    total++; if (ready_m !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", ready_m); end
    total++; if (sout_m !== 1'b0) begin bad++; $display("FAIL mid_rst_sout got=%b want=0", sout_m); end
    total++; if (sout_valid_m !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", sout_valid_m); end
    @(negedge clk);
    rst_ = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      total++; if (done_m !== 1'b0) begin bad++; $display("FAIL mid_no_done c=%0d got=%b want=0", c, done_m); end
      total++; if (sout_valid_m !== 1'b0) begin bad++; $display("FAIL mid_no_valid c=%0d got=%b want=0", c, sout_valid_m); end
      @(negedge clk);
    end
    exp_s = 8'b1000_0001;
    data = 8'h81;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (sout_m !== exp_s[7-k]) begin bad++; $display("FAIL mid_81_sout k=%0d got=%b want=%b", k, sout_m, exp_s[7-k]); end
      total++; if (sout_valid_m !== 1'b1) begin bad++; $display("FAIL mid_81_valid k=%0d got=%b want=1", k, sout_valid_m); end
      @(negedge clk);
    end
    #1;
    total++; if (done_m !== 1'b1) begin bad++; $display("FAIL mid_81_done got=%b want=1", done_m); end
    @(negedge clk); #1;
    total++; if (ready_m !== 1'b1) begin bad++; $display("FAIL mid_81_ready got=%b want=1", ready_m); end
  endtask

  task automatic test_lsb_first;
    logic [7:0] exp_s;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) begin
        data  = 8'h01;
        exp_s = 8'b1000_0000;
      end else begin
        data  = 8'h80;
        exp_s = 8'b0000_0001;
      end
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 8; k++) begin
        #1;
        total++; if (sout_l !== exp_s[7-k]) begin bad++; $display("FAIL lsb_sout f=%0d k=%0d got=%b want=%b", f, k, sout_l, exp_s[7-k]); end
        total++; if (sout_valid_l !== 1'b1) begin bad++; $display("FAIL lsb_valid f=%0d k=%0d got=%b want=1", f, k, sout_valid_l); end
        @(negedge clk);
      end
      #1;
      total++; if (done_l !== 1'b1) begin bad++; $display("FAIL lsb_done f=%0d got=%b want=1", f, done_l); end
      total++; if (state_l !== 2'd2) begin bad++; $display("FAIL lsb_state f=%0d got=%0d want=2", f, state_l); end
      @(negedge clk); #1;
      total++; if (ready_l !== 1'b1) begin bad++; $display("FAIL lsb_ready f=%0d got=%b want=1", f, ready_l); end
    end
  endtask

  initial begin
    rst_ = 1'b0;
    data = 8'h00;
    load = 1'b0;
    hold = 1'b0;
    test_reset();
    test_basic_frame();
    test_load_while_busy();
    test_hold();
    test_reset_mid_frame();
    test_lsb_first();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
